// File: rtl/dm_access_unit.sv
// Data-memory access unit: turns MEM-stage loads/stores into single-word req/ack bus transactions.
// Optional misaligned-access trapping is enabled by defining DM_MISALIGN_TRAP_EN.
module dm_access_unit #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [2:0]    dm_type,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          stall,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          misalign,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic [31:0]   bus_rdata,
  input  logic          bus_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  // Types 101-111 fall into the word case.
  function automatic size_e size_of(input logic [2:0] t);
    case (t)
      3'b001, 3'b010: size_of = SZ_HALF;
      3'b011, 3'b100: size_of = SZ_BYTE;
      default:        size_of = SZ_WORD;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [2:0]    type_q, type_d;
  logic [1:0]    lo_q, lo_d;
  logic          we_q, we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   rdata_q, rdata_d;

  size_e         size_in, size_held;
  logic [3:0]    be_in;
  logic [31:0]   wdata_in;
  logic [1:0]    lane_sel;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;
  logic          accept;

  assign accept   = (state_q == IDLE) && (mem_read || mem_write);
  assign size_in  = size_of(dm_type);
  assign size_held = size_of(type_q);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    be_in    = 4'b1111;
    wdata_in = wdata;
    case (size_in)
      SZ_HALF: begin
        be_in    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        be_in    = 4'b0001 << addr[1:0];
        wdata_in = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection ignores the address bits a given access size cannot use.
  always_comb begin
    lane_sel = 2'b00;
    case (size_held)
      SZ_HALF: lane_sel = {lo_q[1], 1'b0};
      SZ_BYTE: lane_sel = lo_q;
      default: lane_sel = 2'b00;
    endcase
    shifted  = bus_rdata >> {lane_sel, 3'b000};
    load_ext = shifted;
    case (type_q)
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {16'h0000, shifted[15:0]};
      3'b011:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'h000000, shifted[7:0]};
      default: load_ext = shifted;
    endcase
  end

`ifdef DM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic misalign_in;

  assign misalign_in = ((size_in == SZ_HALF) && addr[0]) ||
                       ((size_in == SZ_WORD) && (addr[1:0] != 2'b00));
  assign misalign    = misalign_q;
`else
  assign misalign    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    lo_d        = lo_q;
    we_d        = we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
`ifdef DM_MISALIGN_TRAP_EN
    misalign_d  = misalign_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          type_d      = dm_type;
          lo_d        = addr[1:0];
          we_d        = mem_write;
          bus_addr_d  = {addr[AW-1:2], 2'b00};
          bus_be_d    = be_in;
          bus_wdata_d = wdata_in;
`ifdef DM_MISALIGN_TRAP_EN
          if (misalign_in) begin
            state_d    = DONE;
            misalign_d = 1'b1;
            rdata_d    = 32'h0;
          end else begin
            state_d    = REQ;
          end
`else
          state_d     = REQ;
`endif
        end
      end
      REQ: begin
        if (bus_ack) begin
          rdata_d = we_q ? 32'h0 : load_ext;
          state_d = DONE;
        end
      end
      DONE: begin
        // Strobes still high here belong to the instruction just completed.
        state_d    = IDLE;
        rdata_d    = 32'h0;
`ifdef DM_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      state_q     <= IDLE;
      type_q      <= 3'b000;
      lo_q        <= 2'b00;
      we_q        <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      lo_q        <= lo_d;
      we_q        <= we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef DM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
`endif

  // Reset gates stall directly so the pipeline is released even with a strobe held high.
  assign stall     = rstn && (accept || (state_q == REQ));
  assign done      = (state_q == DONE);
  assign rdata     = rdata_q;
  assign bus_req   = (state_q == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit: loads, stores, wait states, misaligned accesses and reset.
// Expected values are hand-computed constants; DM_MISALIGN_TRAP_EN selects the misalign expectations.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_read, mem_write;
  logic [2:0]  dm_type;
  logic [31:0] addr, wdata;
  logic        stall, done, misalign;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_access_unit #(.AW(32)) dut (
    .clk(clk), .rstn(rstn),
    .mem_read(mem_read), .mem_write(mem_write), .dm_type(dm_type),
    .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full access: accept cycle, (waits+1) REQ cycles with ack on the last, DONE, then strobes drop.
  task automatic run_access(input string tag, input logic rd, input logic wr, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                            input int waits, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic exp_we, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rdata);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; dm_type = t; addr = a; wdata = wd; bus_ack = 1'b0;
    @(negedge clk);
    check({tag, ".acc_stall"}, stall, 1);
    check({tag, ".acc_req"}, bus_req, 0);
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      bus_rdata = rw;
      bus_ack   = (i == waits);
      @(negedge clk);
      check({tag, ".req"}, bus_req, 1);
      check({tag, ".stall"}, stall, 1);
      check({tag, ".done_early"}, done, 0);
      check({tag, ".addr"}, bus_addr, exp_addr);
      check({tag, ".be"}, bus_be, exp_be);
      check({tag, ".we"}, bus_we, exp_we);
      if (exp_we) check({tag, ".wdata"}, bus_wdata, exp_wdata);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check({tag, ".done"}, done, 1);
    check({tag, ".rdata"}, rdata, exp_rdata);
    check({tag, ".done_stall"}, stall, 0);
    check({tag, ".req_fall"}, bus_req, 0);
    check({tag, ".misalign"}, misalign, 0);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".idle_req"}, bus_req, 0);
  endtask

  initial begin
    rstn = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dm_type = 3'b000;
    addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
    #12;
    check("rst.stall", stall, 0);
    check("rst.done", done, 0);
    check("rst.req", bus_req, 0);
    check("rst.we", bus_we, 0);
    check("rst.rdata", rdata, 0);
    check("rst.be", bus_be, 0);
    check("rst.addr", bus_addr, 0);
    check("rst.misalign", misalign, 0);
    @(negedge clk); rstn = 1'b1;

    run_access("lw", 1, 0, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 0,
               32'h100, 4'b1111, 0, 32'h0, 32'hDEADBEEF);
    run_access("sb", 0, 1, 3'b011, 32'h103, 32'h000000A5, 32'h12345678, 0,
               32'h100, 4'b1000, 1, 32'hA5A5A5A5, 32'h0);
    run_access("lb", 1, 0, 3'b011, 32'h201, 32'h0, 32'h80F08123, 0,
               32'h200, 4'b0010, 0, 32'h0, 32'hFFFFFF81);
    run_access("lbu", 1, 0, 3'b100, 32'h201, 32'h0, 32'h80F08123, 0,
               32'h200, 4'b0010, 0, 32'h0, 32'h00000081);
    run_access("lh", 1, 0, 3'b001, 32'h202, 32'h0, 32'h80F08123, 0,
               32'h200, 4'b1100, 0, 32'h0, 32'hFFFF80F0);
    run_access("lhu", 1, 0, 3'b010, 32'h202, 32'h0, 32'h80F08123, 0,
               32'h200, 4'b1100, 0, 32'h0, 32'h000080F0);
    run_access("sh", 0, 1, 3'b001, 32'h12, 32'h1234BEEF, 32'h0, 0,
               32'h10, 4'b1100, 1, 32'hBEEFBEEF, 32'h0);
    run_access("sw_wait", 0, 1, 3'b000, 32'h304, 32'hCAFEF00D, 32'h0, 3,
               32'h304, 4'b1111, 1, 32'hCAFEF00D, 32'h0);
    run_access("lb_wait", 1, 0, 3'b011, 32'h400, 32'h0, 32'h0000007F, 3,
               32'h400, 4'b0001, 0, 32'h0, 32'h0000007F);
    run_access("both", 1, 1, 3'b000, 32'h500, 32'h01020304, 32'hFFFFFFFF, 0,
               32'h500, 4'b1111, 1, 32'h01020304, 32'h0);
    run_access("t111", 1, 0, 3'b111, 32'h40, 32'h0, 32'h89ABCDEF, 0,
               32'h40, 4'b1111, 0, 32'h0, 32'h89ABCDEF);

    // Stray ack while idle must not start anything.
    @(posedge clk); #1; bus_ack = 1'b1;
    @(negedge clk);
    check("stray.req", bus_req, 0);
    check("stray.stall", stall, 0);
    @(posedge clk); #1; bus_ack = 1'b0;
    @(negedge clk);
    check("stray.done", done, 0);

`ifdef DM_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    mem_read = 1'b1; dm_type = 3'b000; addr = 32'h102; bus_rdata = 32'h11223344;
    @(negedge clk);
    check("mis.acc_stall", stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis.req", bus_req, 0);
    check("mis.done", done, 1);
    check("mis.flag", misalign, 1);
    check("mis.rdata", rdata, 0);
    check("mis.stall", stall, 0);
    @(posedge clk); #1; mem_read = 1'b0;
    @(negedge clk);
    check("mis.flag_clr", misalign, 0);
    check("mis.req_after", bus_req, 0);
`else
    run_access("lw_mis", 1, 0, 3'b000, 32'h102, 32'h0, 32'h11223344, 0,
               32'h100, 4'b1111, 0, 32'h0, 32'h11223344);
`endif

    // Reset in the middle of a REQ phase.
    @(posedge clk); #1;
    mem_read = 1'b1; dm_type = 3'b000; addr = 32'h600; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstreq.req_before", bus_req, 1);
    #1 rstn = 1'b0;
    #1;
    check("rstreq.req", bus_req, 0);
    check("rstreq.stall", stall, 0);
    check("rstreq.done", done, 0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk); rstn = 1'b1;
    run_access("post_rst", 1, 0, 3'b100, 32'h703, 32'h0, 32'hC0FFEE11, 0,
               32'h700, 4'b1000, 0, 32'h0, 32'h000000C0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
